// File: rtl/desenha_objetos_multi.sv
// desenha_objetos_multi
//   Renders up to N_OBJ rectangles against the VGA scan counters. Each object
//   has position, size, colour and enable. Updates land in shadow registers
//   through a valid/ready port and are copied to the active set on
//   frame_start, so a frame never shows a half-updated object.
//   Output is a 2-stage registered pipeline: one pixel per cycle, latency 2.
//
// Ports
//   VGA_clk     pixel clock, rising edge
//   reset       synchronous, active-high
//   xCount      current scan column  (XW bits)
//   yCount      current scan row     (YW bits)
//   frame_start one-cycle pulse, commits shadow -> active
//   wr_valid / wr_ready   write handshake (wr_ready low while frame_start=1)
//   wr_obj      target object index; indices >= N_OBJ are accepted and dropped
//   wr_x, wr_y, wr_w, wr_h, wr_color, wr_en_obj   object fields
//   desenho     some enabled object covers the pixel
//   obj_id      winning object (lowest index), 0 when desenho=0
//   color       winning object colour, BG_COLOR when desenho=0
//
// Build option
//   COLLISION_EN : adds output `collision`, a per-frame flag that is set when
//                  two or more objects overlapped on any pixel of the previous
//                  frame.
module desenha_objetos_multi #(
   parameter int N_OBJ = 4,
   parameter int XW = 10,
   parameter int YW = 9,
   parameter int SW = 7,
   parameter int CW = 8,
   parameter logic [CW-1:0] BG_COLOR = '0,
   localparam int OW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
   input  logic          VGA_clk,
   input  logic          reset,
   input  logic [XW-1:0] xCount,
   input  logic [YW-1:0] yCount,
   input  logic          frame_start,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [OW-1:0] wr_obj,
   input  logic [XW-1:0] wr_x,
   input  logic [YW-1:0] wr_y,
   input  logic [SW-1:0] wr_w,
   input  logic [SW-1:0] wr_h,
   input  logic [CW-1:0] wr_color,
   input  logic          wr_en_obj,
   output logic          desenho,
   output logic [OW-1:0] obj_id,
   output logic [CW-1:0] color
`ifdef COLLISION_EN
   ,
   output logic          collision
`endif
);

   logic             ready_q;

   logic [XW-1:0]    sh_x   [N_OBJ];
   logic [YW-1:0]    sh_y   [N_OBJ];
   logic [SW-1:0]    sh_w   [N_OBJ];
   logic [SW-1:0]    sh_h   [N_OBJ];
   logic [CW-1:0]    sh_c   [N_OBJ];
   logic [N_OBJ-1:0] sh_en;

   logic [XW-1:0]    act_x  [N_OBJ];
   logic [YW-1:0]    act_y  [N_OBJ];
   logic [SW-1:0]    act_w  [N_OBJ];
   logic [SW-1:0]    act_h  [N_OBJ];
   logic [CW-1:0]    act_c  [N_OBJ];
   logic [N_OBJ-1:0] act_en;

   logic [N_OBJ-1:0] hit_c;
   logic [N_OBJ-1:0] hit_p1;
   logic [CW-1:0]    color_p1 [N_OBJ];
   logic             vld_p1;

   logic             win_hit;
   logic [OW-1:0]    win_id;
   logic [CW-1:0]    win_color;

   // Writes are refused during the commit cycle so they land in the next
   // frame's shadow instead of racing the copy.
   assign wr_ready = ready_q & ~frame_start;

   // Shadow / active register file
   always_ff @(posedge VGA_clk) begin
      if (reset) begin
         ready_q <= 1'b0;
         sh_en   <= '0;
         act_en  <= '0;
         for (int i = 0; i < N_OBJ; i++) begin
            sh_x[i]  <= '0;
            sh_y[i]  <= '0;
            sh_w[i]  <= '0;
            sh_h[i]  <= '0;
            sh_c[i]  <= '0;
            act_x[i] <= '0;
            act_y[i] <= '0;
            act_w[i] <= '0;
            act_h[i] <= '0;
            act_c[i] <= '0;
         end
      end else begin
         ready_q <= 1'b1;
         for (int i = 0; i < N_OBJ; i++) begin
            // Out-of-range indices match no entry and are silently dropped.
            if (wr_valid && wr_ready && (wr_obj == OW'(i))) begin
               sh_x[i]  <= wr_x;
               sh_y[i]  <= wr_y;
               sh_w[i]  <= wr_w;
               sh_h[i]  <= wr_h;
               sh_c[i]  <= wr_color;
               sh_en[i] <= wr_en_obj;
            end
            if (frame_start) begin
               act_x[i]  <= sh_x[i];
               act_y[i]  <= sh_y[i];
               act_w[i]  <= sh_w[i];
               act_h[i]  <= sh_h[i];
               act_c[i]  <= sh_c[i];
               act_en[i] <= sh_en[i];
            end
         end
      end
   end

   // Per-object hit test. Right/bottom edges are formed one bit wider than
   // the counters so objects running off the screen clip instead of wrapping;
   // a zero width or height makes the interval empty.
   always_comb begin
      hit_c = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         hit_c[i] = act_en[i]
            && ({1'b0, xCount} >= {1'b0, act_x[i]})
            && ({1'b0, xCount} <  ({1'b0, act_x[i]} + (XW+1)'(act_w[i])))
            && ({1'b0, yCount} >= {1'b0, act_y[i]})
            && ({1'b0, yCount} <  ({1'b0, act_y[i]} + (YW+1)'(act_h[i])));
      end
   end

   // ---- stage 1: hit vector and colour snapshot ----
   always_ff @(posedge VGA_clk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         hit_p1 <= '0;
         for (int i = 0; i < N_OBJ; i++) color_p1[i] <= '0;
      end else begin
         vld_p1 <= 1'b1;
         hit_p1 <= hit_c;
         for (int i = 0; i < N_OBJ; i++) color_p1[i] <= act_c[i];
      end
   end

   // Fixed priority: scanning downward leaves the lowest hit index in place.
   always_comb begin
      win_hit   = 1'b0;
      win_id    = '0;
      win_color = BG_COLOR;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (hit_p1[i]) begin
            win_hit   = 1'b1;
            win_id    = OW'(i);
            win_color = color_p1[i];
         end
      end
   end

   // ---- stage 2: registered outputs ----
   always_ff @(posedge VGA_clk) begin
      if (reset || !vld_p1) begin
         desenho <= 1'b0;
         obj_id  <= '0;
         color   <= BG_COLOR;
      end else begin
         desenho <= win_hit;
         obj_id  <= win_id;
         color   <= win_color;
      end
   end

`ifdef COLLISION_EN
   logic multi_p1;
   logic seen_hit;
   logic coll_flag;

   always_comb begin
      multi_p1 = 1'b0;
      seen_hit = 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
         if (hit_p1[i]) begin
            if (seen_hit) multi_p1 = 1'b1;
            seen_hit = 1'b1;
         end
      end
   end

   // Sticky flag accumulates over a frame and is published on frame_start.
   always_ff @(posedge VGA_clk) begin
      if (reset) begin
         coll_flag <= 1'b0;
         collision <= 1'b0;
      end else if (frame_start) begin
         collision <= coll_flag;
         coll_flag <= 1'b0;
      end else if (multi_p1) begin
         coll_flag <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_desenha_objetos_multi.sv
module tb_desenha_objetos_multi;
   localparam int N_OBJ = 3;
   localparam int XW = 10;
   localparam int YW = 9;
   localparam int SW = 7;
   localparam int CW = 8;
   localparam int OW = 2;
   localparam logic [CW-1:0] BG = 8'h15;

   logic          VGA_clk = 1'b0;
   logic          reset = 1'b1;
   logic [XW-1:0] xCount = '0;
   logic [YW-1:0] yCount = '0;
   logic          frame_start = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [OW-1:0] wr_obj = '0;
   logic [XW-1:0] wr_x = '0;
   logic [YW-1:0] wr_y = '0;
   logic [SW-1:0] wr_w = '0;
   logic [SW-1:0] wr_h = '0;
   logic [CW-1:0] wr_color = '0;
   logic          wr_en_obj = 1'b0;
   logic          desenho;
   logic [OW-1:0] obj_id;
   logic [CW-1:0] color;

   int total = 0;
   int bad = 0;

   // behavioural model: shadow and active object tables
   int s_x[N_OBJ], s_y[N_OBJ], s_w[N_OBJ], s_h[N_OBJ], s_c[N_OBJ], s_en[N_OBJ];
   int a_x[N_OBJ], a_y[N_OBJ], a_w[N_OBJ], a_h[N_OBJ], a_c[N_OBJ], a_en[N_OBJ];

   int   q_x[$], q_y[$];
   logic got_d[$];
   logic [OW-1:0] got_id[$];
   logic [CW-1:0] got_c[$];

   desenha_objetos_multi #(
      .N_OBJ(N_OBJ), .XW(XW), .YW(YW), .SW(SW), .CW(CW), .BG_COLOR(BG)
   ) dut (
      .VGA_clk(VGA_clk), .reset(reset), .xCount(xCount), .yCount(yCount),
      .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_obj(wr_obj), .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h),
      .wr_color(wr_color), .wr_en_obj(wr_en_obj),
      .desenho(desenho), .obj_id(obj_id), .color(color)
   );

   always #5 VGA_clk = ~VGA_clk;

   function automatic void model_clear();
      for (int i = 0; i < N_OBJ; i++) begin
         s_x[i] = 0; s_y[i] = 0; s_w[i] = 0; s_h[i] = 0; s_c[i] = 0; s_en[i] = 0;
         a_x[i] = 0; a_y[i] = 0; a_w[i] = 0; a_h[i] = 0; a_c[i] = 0; a_en[i] = 0;
      end
   endfunction

   function automatic void model_write(int o, int x, int y, int w, int h, int c, int en);
      if (o < N_OBJ) begin
         s_x[o] = x; s_y[o] = y; s_w[o] = w; s_h[o] = h; s_c[o] = c; s_en[o] = en;
      end
   endfunction

   function automatic void model_commit();
      for (int i = 0; i < N_OBJ; i++) begin
         a_x[i] = s_x[i]; a_y[i] = s_y[i]; a_w[i] = s_w[i];
         a_h[i] = s_h[i]; a_c[i] = s_c[i]; a_en[i] = s_en[i];
      end
   endfunction

   // first enabled object whose w x h rectangle contains the pixel wins
   task automatic model_pix(input int px, input int py, output bit d, output int id, output int col);
      d = 0; id = 0; col = int'(BG);
      for (int i = 0; i < N_OBJ; i++) begin
         if (!d && a_en[i] != 0 && px >= a_x[i] && px < a_x[i] + a_w[i]
             && py >= a_y[i] && py < a_y[i] + a_h[i]) begin
            d = 1; id = i; col = a_c[i];
         end
      end
   endtask

   task automatic step();
      @(posedge VGA_clk);
      #1;
   endtask

   task automatic do_write(int o, int x, int y, int w, int h, int c, int en);
      wr_obj = OW'(o); wr_x = XW'(x); wr_y = YW'(y); wr_w = SW'(w);
      wr_h = SW'(h); wr_color = CW'(c); wr_en_obj = en[0];
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      model_write(o, x, y, w, h, c, en);
   endtask

   task automatic do_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      model_commit();
   endtask

   task automatic pts_rect(int x0, int x1, int y0, int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) begin
            q_x.push_back(x); q_y.push_back(y);
         end
   endtask

   // drives q_x/q_y back to back and records the outputs 2 cycles later
   task automatic scan_pts();
      got_d.delete(); got_id.delete(); got_c.delete();
      for (int k = 0; k <= q_x.size(); k++) begin
         if (k < q_x.size()) begin
            xCount = XW'(q_x[k]); yCount = YW'(q_y[k]);
         end
         step();
         if (k >= 1) begin
            got_d.push_back(desenho); got_id.push_back(obj_id); got_c.push_back(color);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         xCount = XW'($urandom_range(0, 1023)); yCount = YW'($urandom_range(0, 511));
         step();
      end
      total++;
      if (desenho !== 1'b0 || obj_id !== '0 || color !== BG) begin
         bad++;
         $display("FAIL reset_out: got d=%b id=%0d c=%h, want d=0 id=0 c=%h", desenho, obj_id, color, BG);
      end
      total++;
      if (wr_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready: got %b want 0", wr_ready);
      end
      reset = 1'b0;
      model_clear();
      step(); step();
      total++;
      if (wr_ready !== 1'b1) begin
         bad++; $display("FAIL ready_after_reset: got %b want 1", wr_ready);
      end
      q_x.delete(); q_y.delete();
      for (int k = 0; k < 40; k++) begin
         q_x.push_back($urandom_range(0, 1023)); q_y.push_back($urandom_range(0, 511));
      end
      scan_pts();
      for (int i = 0; i < q_x.size(); i++) begin
         total++;
         if (got_d[i] !== 1'b0 || got_id[i] !== '0 || got_c[i] !== BG) begin
            bad++;
            $display("FAIL empty_scan (%0d,%0d): got d=%b id=%0d c=%h want background", q_x[i], q_y[i], got_d[i], got_id[i], got_c[i]);
         end
      end
   endtask

   task automatic test_single();
      bit d; int id, col;
      do_write(0, 100, 50, 10, 4, 8'h3C, 1);
      // not yet committed: nothing drawn
      q_x.delete(); q_y.delete();
      pts_rect(100, 109, 50, 50);
      scan_pts();
      for (int i = 0; i < q_x.size(); i++) begin
         total++;
         if (got_d[i] !== 1'b0) begin
            bad++; $display("FAIL shadow_only (%0d,%0d): got d=%b want 0", q_x[i], q_y[i], got_d[i]);
         end
      end
      do_frame();
      q_x.delete(); q_y.delete();
      pts_rect(98, 111, 49, 55);
      scan_pts();
      for (int i = 0; i < q_x.size(); i++) begin
         model_pix(q_x[i], q_y[i], d, id, col);
         total++;
         if (got_d[i] !== d || got_id[i] !== OW'(id) || got_c[i] !== CW'(col)) begin
            bad++;
            $display("FAIL single (%0d,%0d): got d=%b id=%0d c=%h want d=%0d id=%0d c=%h", q_x[i], q_y[i], got_d[i], got_id[i], got_c[i], d, id, col);
         end
      end
   endtask

   task automatic test_overlap();
      bit d; int id, col;
      do_write(1, 105, 50, 10, 4, 8'hA0, 1);
      do_frame();
      q_x.delete(); q_y.delete();
      q_x.push_back(107); q_y.push_back(51);
      q_x.push_back(112); q_y.push_back(51);
      pts_rect(95, 120, 49, 55);
      scan_pts();
      total++;
      if (got_d[0] !== 1'b1 || got_id[0] !== 2'd0 || got_c[0] !== 8'h3C) begin
         bad++; $display("FAIL overlap_107: got d=%b id=%0d c=%h want d=1 id=0 c=3c", got_d[0], got_id[0], got_c[0]);
      end
      total++;
      if (got_d[1] !== 1'b1 || got_id[1] !== 2'd1 || got_c[1] !== 8'hA0) begin
         bad++; $display("FAIL overlap_112: got d=%b id=%0d c=%h want d=1 id=1 c=a0", got_d[1], got_id[1], got_c[1]);
      end
      for (int i = 2; i < q_x.size(); i++) begin
         model_pix(q_x[i], q_y[i], d, id, col);
         total++;
         if (got_d[i] !== d || got_id[i] !== OW'(id) || got_c[i] !== CW'(col)) begin
            bad++;
            $display("FAIL overlap (%0d,%0d): got d=%b id=%0d c=%h want d=%0d id=%0d c=%h", q_x[i], q_y[i], got_d[i], got_id[i], got_c[i], d, id, col);
         end
      end
   endtask

   task automatic test_clip();
      bit d; int id, col;
      do_write(0, 1020, 50, 10, 4, 8'h77, 1);
      do_frame();
      q_x.delete(); q_y.delete();
      pts_rect(1014, 1023, 49, 54);
      pts_rect(0, 6, 49, 54);
      scan_pts();
      for (int i = 0; i < q_x.size(); i++) begin
         model_pix(q_x[i], q_y[i], d, id, col);
         total++;
         if (got_d[i] !== d || got_id[i] !== OW'(id) || got_c[i] !== CW'(col)) begin
            bad++;
            $display("FAIL clip (%0d,%0d): got d=%b id=%0d c=%h want d=%0d id=%0d c=%h", q_x[i], q_y[i], got_d[i], got_id[i], got_c[i], d, id, col);
         end
      end
   endtask

   task automatic test_write_at_frame();
      bit d; int id, col;
      frame_start = 1'b1;
      wr_valid = 1'b1; wr_obj = 2'd2; wr_x = 10'd600; wr_y = 9'd300;
      wr_w = 7'd8; wr_h = 7'd8; wr_color = 8'h5A; wr_en_obj = 1'b1;
      #1;
      total++;
      if (wr_ready !== 1'b0) begin
         bad++; $display("FAIL ready_at_frame: got %b want 0", wr_ready);
      end
      step();
      model_commit();
      frame_start = 1'b0;
      #1;
      total++;
      if (wr_ready !== 1'b1) begin
         bad++; $display("FAIL ready_after_frame: got %b want 1", wr_ready);
      end
      step();
      wr_valid = 1'b0;
      model_write(2, 600, 300, 8, 8, 8'h5A, 1);
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) do_frame();
         q_x.delete(); q_y.delete();
         pts_rect(598, 609, 298, 309);
         scan_pts();
         for (int i = 0; i < q_x.size(); i++) begin
            model_pix(q_x[i], q_y[i], d, id, col);
            total++;
            if (got_d[i] !== d || got_id[i] !== OW'(id) || got_c[i] !== CW'(col)) begin
               bad++;
               $display("FAIL frame_write p%0d (%0d,%0d): got d=%b id=%0d c=%h want d=%0d id=%0d c=%h", pass, q_x[i], q_y[i], got_d[i], got_id[i], got_c[i], d, id, col);
            end
         end
      end
      // (603,303) is index 5*12+5 of the last scan
      total++;
      if (got_d[65] !== 1'b1 || got_id[65] !== 2'd2 || got_c[65] !== 8'h5A) begin
         bad++; $display("FAIL frame_write_visible: got d=%b id=%0d c=%h want d=1 id=2 c=5a", got_d[65], got_id[65], got_c[65]);
      end
   endtask

   task automatic test_zero_oob();
      bit d; int id, col;
      do_write(2, 200, 100, 0, 8, 8'hEE, 1);
      wr_obj = 2'd3; wr_x = 10'd300; wr_y = 9'd200; wr_w = 7'd20; wr_h = 7'd20;
      wr_color = 8'hFF; wr_en_obj = 1'b1; wr_valid = 1'b1;
      #1;
      total++;
      if (wr_ready !== 1'b1) begin
         bad++; $display("FAIL oob_ready: got %b want 1", wr_ready);
      end
      step();
      wr_valid = 1'b0;
      model_write(3, 300, 200, 20, 20, 8'hFF, 1);
      do_frame();
      q_x.delete(); q_y.delete();
      pts_rect(198, 204, 99, 109);
      pts_rect(296, 322, 205, 206);
      pts_rect(1018, 1023, 51, 51);
      pts_rect(103, 113, 52, 52);
      scan_pts();
      for (int i = 0; i < q_x.size(); i++) begin
         model_pix(q_x[i], q_y[i], d, id, col);
         total++;
         if (got_d[i] !== d || got_id[i] !== OW'(id) || got_c[i] !== CW'(col)) begin
            bad++;
            $display("FAIL zero_oob (%0d,%0d): got d=%b id=%0d c=%h want d=%0d id=%0d c=%h", q_x[i], q_y[i], got_d[i], got_id[i], got_c[i], d, id, col);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit d; int id, col;
      do_write(1, 400, 400, 5, 5, 8'h11, 1);
      xCount = 10'd1021; yCount = 9'd51;
      step(); step();
      total++;
      if (desenho !== 1'b1 || color !== 8'h77) begin
         bad++; $display("FAIL pre_reset_hit: got d=%b c=%h want d=1 c=77", desenho, color);
      end
      reset = 1'b1;
      step();
      total++;
      if (desenho !== 1'b0 || obj_id !== '0 || color !== BG || wr_ready !== 1'b0) begin
         bad++; $display("FAIL mid_reset: got d=%b id=%0d c=%h rdy=%b want d=0 id=0 c=%h rdy=0", desenho, obj_id, color, wr_ready, BG);
      end
      reset = 1'b0;
      model_clear();
      step();
      do_frame();
      q_x.delete(); q_y.delete();
      pts_rect(399, 405, 399, 405);
      pts_rect(1018, 1023, 50, 52);
      pts_rect(100, 112, 51, 51);
      scan_pts();
      for (int i = 0; i < q_x.size(); i++) begin
         model_pix(q_x[i], q_y[i], d, id, col);
         total++;
         if (got_d[i] !== d || got_id[i] !== OW'(id) || got_c[i] !== CW'(col)) begin
            bad++;
            $display("FAIL after_reset (%0d,%0d): got d=%b id=%0d c=%h want d=%0d id=%0d c=%h", q_x[i], q_y[i], got_d[i], got_id[i], got_c[i], d, id, col);
         end
      end
   endtask

   // random writes and commits interleaved with a continuous pixel stream
   task automatic test_random();
      int n = 1500;
      int ex_d[$], ex_id[$], ex_c[$], ex_x[$], ex_y[$];
      bit d; int id, col;
      int x, y, o, r;
      int ro, rx, ry, rw, rh, rc, ren;
      for (int i = 0; i < N_OBJ; i++)
         do_write(i, $urandom_range(0, 900), $urandom_range(0, 450), $urandom_range(1, 127),
                  $urandom_range(1, 127), $urandom_range(0, 255), 1);
      do_frame();
      for (int k = 0; k <= n; k++) begin
         frame_start = 1'b0;
         wr_valid = 1'b0;
         if (k < n) begin
            if ($urandom_range(0, 3) != 0) begin
               o = $urandom_range(0, N_OBJ - 1);
               x = a_x[o] + $urandom_range(0, a_w[o] + 1) - 1;
               y = a_y[o] + $urandom_range(0, a_h[o] + 1) - 1;
               if (x < 0) x = 0;
               if (x > 1023) x = 1023;
               if (y < 0) y = 0;
               if (y > 511) y = 511;
            end else begin
               x = $urandom_range(0, 1023); y = $urandom_range(0, 511);
            end
            xCount = XW'(x); yCount = YW'(y);
            model_pix(x, y, d, id, col);
            ex_d.push_back(d); ex_id.push_back(id); ex_c.push_back(col);
            ex_x.push_back(x); ex_y.push_back(y);
            r = $urandom_range(0, 99);
            if (r < 2) frame_start = 1'b1;
            else if (r < 12) begin
               ro = $urandom_range(0, 3); rx = $urandom_range(0, 1023); ry = $urandom_range(0, 511);
               rw = $urandom_range(0, 127); rh = $urandom_range(0, 127); rc = $urandom_range(0, 255);
               ren = ($urandom_range(0, 4) != 0) ? 1 : 0;
               wr_obj = OW'(ro); wr_x = XW'(rx); wr_y = YW'(ry); wr_w = SW'(rw);
               wr_h = SW'(rh); wr_color = CW'(rc); wr_en_obj = ren[0];
               wr_valid = 1'b1;
            end
         end
         step();
         if (frame_start) model_commit();
         if (wr_valid) model_write(ro, rx, ry, rw, rh, rc, ren);
         if (k >= 1) begin
            total++;
            if (desenho !== ex_d[0][0] || obj_id !== OW'(ex_id[0]) || color !== CW'(ex_c[0])) begin
               bad++;
               $display("FAIL random (%0d,%0d): got d=%b id=%0d c=%h want d=%0d id=%0d c=%h", ex_x[0], ex_y[0], desenho, obj_id, color, ex_d[0], ex_id[0], ex_c[0]);
            end
            void'(ex_d.pop_front()); void'(ex_id.pop_front()); void'(ex_c.pop_front());
            void'(ex_x.pop_front()); void'(ex_y.pop_front());
         end
      end
      frame_start = 1'b0;
      wr_valid = 1'b0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single();
      test_overlap();
      test_clip();
      test_write_at_frame();
      test_zero_oob();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/desenha_objetos_multi.md
Name: desenha_objetos_multi

Overview:
- Parametrised successor of the single-square draw test: renders up to N_OBJ rectangular objects against the VGA scan counters.
- Each object has independent position, width, height, colour and enable.
- Object updates are written into shadow registers through a valid/ready port and committed atomically at frame start, so there is no tearing.
- Sits between the VGA timing generator (xCount/yCount) and the pixel colour mux. Outputs are a 2-cycle registered pipeline.

Parameters:
- N_OBJ, 4, number of objects; index 0 has highest priority.
- XW, 10, width of xCount and x positions.
- YW, 9, width of yCount and y positions.
- SW, 7, width of object width/height fields.
- CW, 8, colour width.
- BG_COLOR, 0, colour output when no object hits.

Ports:
- VGA_clk  input  1  pixel clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- xCount  input  XW  current scan column.
- yCount  input  YW  current scan row.
- frame_start  input  1  one-cycle pulse from the timing generator; commits shadow to active.
- wr_valid  input  1  write request.
- wr_ready  output  1  write accepted when wr_valid && wr_ready.
- wr_obj  input  clog2(N_OBJ) (min 1)  target object index.
- wr_x  input  XW  object left edge.
- wr_y  input  YW  object top edge.
- wr_w  input  SW  object width in pixels.
- wr_h  input  SW  object height in pixels.
- wr_color  input  CW  object colour.
- wr_en_obj  input  1  object enable.
- desenho  output  1  some enabled object covers the pixel.
- obj_id  output  clog2(N_OBJ)  index of the winning object; 0 when desenho=0.
- color  output  CW  colour of the winning object, else BG_COLOR.

Behaviour:
- Reset (synchronous, while reset=1):
  - All shadow and active entries cleared: x=y=w=h=0, color=0, enable=0.
  - desenho=0, obj_id=0, color=BG_COLOR; both pipeline stages cleared.
  - wr_ready=0 during reset, 1 from the first cycle after reset deasserts.
- Hit rule per object i, with all comparisons on active registers:
  - x hit: x_i <= xCount < x_i + w_i.
  - y hit: y_i <= yCount < y_i + h_i.
  - The object covers exactly w_i × h_i pixels.
  - Sums are computed at XW+1 / YW+1 bits with no wrap; an object extending past the counter range is clipped, never wrapped to 0.
  - w_i=0 or h_i=0 means the object is never drawn.
  - Object hits only when enable_i=1.
- Pipeline:
  - Stage 1 registers the per-object hit vector plus a copy of each colour.
  - Stage 2 performs a fixed-priority encode (lowest index wins) and registers desenho/obj_id/color.
  - Latency is exactly 2 VGA_clk cycles from xCount/yCount to outputs; throughput is one pixel per cycle.
- Write port:
  - On wr_valid && wr_ready, shadow[wr_obj] is loaded with all fields in that cycle.
  - wr_obj >= N_OBJ: the handshake completes and data is dropped.
  - wr_ready=0 in any cycle where frame_start=1; a write presented then is held by the master and accepted the next cycle, into the next frame's shadow.
  - Multiple writes to the same index within a frame: last write wins.
- Commit:
  - On frame_start=1, every active entry is loaded from its shadow entry in the same edge.
  - Pixels already in the pipeline finish with the old values.
  - New values affect pixels whose xCount/yCount are sampled from the next cycle on.
- Reset mid-frame: the pipeline flushes, outputs return to reset values, and pending shadow writes are lost.

Optional Feature:
- COLLISION_EN defined: adds output `collision` (1 bit).
  - An internal sticky flag sets whenever stage 1 has 2 or more enabled hits on the same pixel.
  - On frame_start, `collision` is loaded with the sticky flag and the flag clears. `collision` is thus a per-frame result valid for the whole next frame.
  - Reset clears both the flag and `collision`.
- COLLISION_EN undefined: no port and no logic; behaviour is otherwise identical.

Test Plan:
- Reset then scan with no writes: desenho=0, color=BG_COLOR, obj_id=0 for all pixels; wr_ready=1 after reset.
- Write obj0 x=100 y=50 w=10 h=4 color=0x3C en=1, then pulse frame_start:
  - desenho=1 for x 100..109, y 50..53, seen 2 cycles after the counters.
  - x=99, x=110 and y=54 give 0.
- Write obj1 overlapping obj0 (x=105 y=50 w=10 h=4 color=0xA0):
  - pixel (107,51) shows obj_id=0, color=0x3C;
  - pixel (112,51) shows obj_id=1, color=0xA0;
  - with COLLISION_EN, `collision`=1 after the next frame_start.
- Write obj0 x=1020 w=10 with XW=10: the object is drawn at x 1020..1023 only, with no hits at x 0..5.
- Assert wr_valid in the same cycle as frame_start: wr_ready=0, the write is accepted next cycle, and the new value appears only after the following frame_start.
- Write obj2 with w=0, h=8, en=1 and commit: never drawn; with wr_obj=N_OBJ, the handshake completes and no object changes.
